// File: rtl/per1_mem_master_bridge.sv
// Master-side bridge from the core load/store port to the per1 memory slave:
// alignment check, two-phase strobe/data handshake, load extension and wait timeout.
module per1_mem_master_bridge #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_slave_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [15:0]      r_addr;
    logic [1:0]       r_size;
    logic             r_we;
    logic             r_uns;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic             w_bad;
    logic             w_in_slave;
    logic             w_resp;
    logic             w_timeout;

    function automatic logic [31:0] f_extend(input logic [1:0]  size,
                                             input logic        uns,
                                             input logic [31:0] d);
        case (size)
            2'b00:   f_extend = {{24{~uns & d[7]}}, d[7:0]};
            2'b01:   f_extend = {{16{~uns & d[15]}}, d[15:0]};
            default: f_extend = d;
        endcase
    endfunction

    function automatic logic f_illegal(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   f_illegal = 1'b0;
            2'b01:   f_illegal = a[0];
            2'b10:   f_illegal = (a != 2'b00);
            default: f_illegal = 1'b1;
        endcase
    endfunction

    assign w_bad      = f_illegal(req_size, req_addr[1:0]);
    assign w_in_slave = (r_state == S_REQ) || (r_state == S_DATA);
    assign w_resp     = (r_state == S_RESP);
    assign w_timeout  = (r_cnt == CNT_LAST);

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = w_resp;
    assign resp_rdata = w_resp ? r_rdata : 32'd0;
    assign resp_err   = w_resp & r_err;

    // Slave-facing fields come straight from the latched request so they stay
    // stable across both phases; the write commits during DATA.
    assign mem_addr   = r_addr;
    assign mem_size   = r_size;
    assign mem_wdata  = r_wdata;
    assign mem_wr_en  = r_we & w_in_slave;
    assign mem_rd_en  = (r_state == S_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= 16'd0;
            r_size  <= 2'd0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_wdata <= 32'd0;
            r_cnt   <= '0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_size  <= req_size;
                        r_we    <= req_we;
                        r_uns   <= req_unsigned;
                        r_wdata <= req_wdata;
                        r_cnt   <= '0;
                        r_rdata <= 32'd0;
                        r_err   <= w_bad;
                        r_state <= w_bad ? S_RESP : S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_slave_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (mem_slave_ready) begin
                        if (!r_we) begin
                            r_rdata <= f_extend(r_size, r_uns, mem_rdata);
                        end
                        r_cnt   <= '0;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_per1_mem_master_bridge.sv
// Scoreboard bench for per1_mem_master_bridge with a behavioural per1 slave model.
module tb_per1_mem_master_bridge;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_slave_ready;

    per1_mem_master_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_slave_ready(mem_slave_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave model: byte memory, combinational ready with optional stall/hang.
    logic [7:0]  mem [0:65535];
    logic [15:0] a0, a1, a2, a3;
    int          req_cyc;
    int          busy_n = 0;
    logic        hang = 1'b0;
    logic        phase;
    int          rd_cnt;
    int          cyc;
    int          acc_last;
    logic        chk_store = 1'b0;

    assign a0 = mem_addr;
    assign a1 = mem_addr + 16'd1;
    assign a2 = mem_addr + 16'd2;
    assign a3 = mem_addr + 16'd3;
    assign mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
    assign mem_slave_ready = !hang && (!mem_rd_en || (req_cyc >= busy_n));

    always @(posedge clk) begin
        req_cyc <= mem_rd_en ? req_cyc + 1 : 0;
        cyc     <= cyc + 1;
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (req_valid && req_ready) acc_last <= cyc;
    end

    initial begin
        req_cyc  = 0;
        cyc      = 0;
        rd_cnt   = 0;
        acc_last = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= 1'b0;
        else if (!phase && mem_rd_en && mem_slave_ready) phase <= 1'b1;
        else if (phase && mem_slave_ready) phase <= 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n && phase && mem_slave_ready && mem_wr_en) begin
            mem[a0] <= mem_wdata[7:0];
            if (mem_size != 2'b00) mem[a1] <= mem_wdata[15:8];
            if (mem_size == 2'b10) begin
                mem[a2] <= mem_wdata[23:16];
                mem[a3] <= mem_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_latency", cyc - acc_last, e.lat);
                chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
            end
        end
        if (chk_store && (mem_rd_en || phase)) begin
            chk("store_wr_en", {31'd0, mem_wr_en}, 32'd1);
            chk("store_wdata", mem_wdata, 32'hABCD5AA5);
            chk("store_addr", {16'd0, mem_addr}, 32'h0040);
            chk("store_size", {30'd0, mem_size}, 32'd1);
        end
    end

    task automatic issue(input logic we, input logic [15:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int el, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        req_valid    = 1'b1;
        if (push) begin
            e.rdata = er;
            e.err   = ee;
            e.lat   = el;
            sb.push_back(e);
        end
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (push) begin
            n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("resp_wait", sb.size(), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_mem_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_mem_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
        chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_size"}, {30'd0, mem_size}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int rd_before;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h78; mem[16'h0011] = 8'h56;
        mem[16'h0012] = 8'h34; mem[16'h0013] = 8'h12;
        mem[16'h0021] = 8'h80;
        mem[16'h0022] = 8'h01; mem[16'h0023] = 8'h80;
        mem[16'h0040] = 8'h11; mem[16'h0041] = 8'h22;
        mem[16'h0042] = 8'h33; mem[16'h0043] = 8'h44;
        mem[16'hFFFC] = 8'hEF; mem[16'hFFFD] = 8'hBE;
        mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'hDE;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'd0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'd0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 32'h12345678, 1'b0, 3, 1'b1);
        issue(1'b0, 16'h0021, 2'b00, 1'b0, 32'd0, 32'hFFFFFF80, 1'b0, 3, 1'b1);
        issue(1'b0, 16'h0021, 2'b00, 1'b1, 32'd0, 32'h00000080, 1'b0, 3, 1'b1);
        issue(1'b0, 16'h0022, 2'b01, 1'b0, 32'd0, 32'hFFFF8001, 1'b0, 3, 1'b1);

        chk_store = 1'b1;
        issue(1'b1, 16'h0040, 2'b01, 1'b0, 32'hABCD5AA5, 32'd0, 1'b0, 3, 1'b1);
        chk_store = 1'b0;
        chk("mem_40", {24'd0, mem[16'h0040]}, 32'hA5);
        chk("mem_41", {24'd0, mem[16'h0041]}, 32'h5A);
        chk("mem_42", {24'd0, mem[16'h0042]}, 32'h33);
        chk("mem_43", {24'd0, mem[16'h0043]}, 32'h44);
        issue(1'b0, 16'h0040, 2'b10, 1'b0, 32'd0, 32'h44335AA5, 1'b0, 3, 1'b1);

        rd_before = rd_cnt;
        issue(1'b0, 16'h0042, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 1, 1'b1);
        issue(1'b0, 16'h0043, 2'b01, 1'b0, 32'd0, 32'd0, 1'b1, 1, 1'b1);
        issue(1'b0, 16'h0010, 2'b11, 1'b0, 32'd0, 32'd0, 1'b1, 1, 1'b1);
        chk("err_no_strobe", rd_cnt - rd_before, 32'd0);

        busy_n = 5;
        issue(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 32'h12345678, 1'b0, 8, 1'b1);
        busy_n = 0;

        issue(1'b0, 16'hFFFC, 2'b10, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, 3, 1'b1);

        hang = 1'b1;
        issue(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, TIMEOUT + 1, 1'b1);
        hang = 1'b0;
        @(negedge clk);
        chk("idle_after_timeout", {31'd0, req_ready}, 32'd1);

        // Reset while the bridge sits in DATA: no response may follow.
        issue(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #3 chk("in_data_phase", {31'd0, phase}, 32'd1);
        rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_resp_after_rst", sb.size(), 32'd0);

        issue(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 32'h12345678, 1'b0, 3, 1'b1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/per1_mem_master_bridge.md
Name: per1_mem_master_bridge

Overview:
- Master-side bridge between the core load/store unit and the per1 external memory slave.
- Accepts one load/store request at a time with a valid/ready handshake.
- Checks alignment, then runs the slave's two-phase protocol: a request phase (strobe until slave_ready) and a data phase (slave_ready again; read data valid, write committed).
- Returns a one-cycle response carrying sign/zero-extended read data or an error flag, and bounds every slave wait with a timeout.

Parameters:
TIMEOUT, 64, max cycles spent in REQ or DATA waiting for mem_slave_ready before aborting with error (>=2)
CNT_W, 7, width of the wait counter; must hold TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core request present
req_ready  output  1  bridge can accept a request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_addr  input  16  byte address
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  qualifies resp_valid: misaligned, illegal size, or timeout
mem_addr  output  16  slave address
mem_size  output  2  slave size_select
mem_wdata  output  32  slave write_data
mem_wr_en  output  1  slave wr_en
mem_rd_en  output  1  slave request strobe, asserted for loads AND stores
mem_rdata  input  32  slave read_data: bytes addr+3..addr, addr byte in [7:0]
mem_slave_ready  input  1  slave ready; combinational from slave

Behaviour:
- Reset (async, rst_n low): state=IDLE; all latched request fields and wait_cnt cleared.
- Reset output values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_size=0, mem_wdata=0.
- Reset mid-transaction: abandon immediately; no response is issued.
- Latched fields: addr, size, we, unsigned, wdata. mem_addr/mem_size/mem_wdata/mem_wr_en are driven from these registers and stay stable from REQ through DATA.
- State IDLE: req_ready=1. When req_valid is high, latch the fields.
  - Error if req_size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0. On error go to RESP with err set; no slave access.
  - Otherwise go to REQ.
- State REQ: mem_rd_en=1; wait_cnt increments each cycle.
  - mem_slave_ready=1 -> DATA, wait_cnt cleared.
  - Otherwise, wait_cnt reaching TIMEOUT-1 -> RESP with err set.
- State DATA: mem_rd_en=0; mem_wr_en and mem_wdata held, because the slave commits the write during this cycle.
  - mem_slave_ready=1: for loads, capture extended mem_rdata into resp_rdata; go to RESP.
  - Otherwise, count as in REQ; timeout -> RESP with err set.
  - A timeout abort does not cancel a write already latched by the slave.
- State RESP: resp_valid=1 for exactly one cycle; then IDLE. req_ready=0.
- Load extension:
  - byte: b=mem_rdata[7:0]; result {24{~unsigned & b[7]}, b}.
  - half: h=mem_rdata[15:0]; result {16{~unsigned & h[15]}, h}.
  - word: raw mem_rdata.
- Stores return resp_rdata=0. Errors return resp_rdata=0 and resp_err=1.
- mem_wr_en is driven low outside REQ/DATA.
- Latency with no stalls: request accepted at edge N; REQ in cycle N+1; DATA in N+2; resp_valid in N+3. Throughput is one transaction per 4 cycles.
- Address wrap: an aligned word at 0xFFFC is legal. Alignment rules make 16-bit wrap at addr+3 impossible.
- req_valid during REQ/DATA/RESP is ignored (req_ready=0); the core holds it.
- mem_slave_ready outside REQ/DATA is ignored.

Test Plan:
- Word load at 0x0010, slave bytes [0x10..0x13]=0x78,0x56,0x34,0x12, slave always ready -> resp_valid exactly 3 cycles after acceptance, resp_rdata=0x12345678, resp_err=0.
- Byte load at 0x0021 (byte 0x80), req_unsigned=0 then 1 -> 0xFFFFFF80 then 0x00000080. Half load at 0x0022 (0x8001) signed -> 0xFFFF8001.
- Half store 0xABCD5AA5 at 0x0040 then word load at 0x0040 -> slave bytes 0x40=0xA5, 0x41=0x5A, 0x42/0x43 unchanged; mem_wdata/mem_wr_en stable across REQ and DATA; store resp_rdata=0.
- Misaligned word load at 0x0042, half at 0x0043, and size=11 -> resp_err=1 one cycle after acceptance; mem_rd_en never asserted.
- Slave busy (slave_ready low) for 5 cycles in REQ, then ready -> correct data, latency 3+5. Busy held for TIMEOUT cycles -> resp_err=1, resp_rdata=0, bridge back in IDLE with req_ready=1.
- rst_n pulsed low while in DATA -> all outputs at reset values asynchronously, no resp_valid; the next word load completes normally.
